// File: rtl/alu_issue_ctrl.sv
// Purpose : single-issue sequencer feeding the ALU operand-mux stage (RD_A -> RD_B -> ISSUE -> WAIT -> WB).
// Latency : accept edge to alu_en = 3 cycles; alu_done sample to rf_we = 1 cycle; minimum 6 cycles per instruction.
// Backpr. : instr_ready high only in IDLE; a hung ALU is aborted after TIMEOUT WAIT cycles with an err pulse.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   instr_valid/instr_ready/instr     instruction handshake ([15:12] op, [11:10] rd, [9:8] rs, [7:0] offset)
//   rf_raddr/rf_rdata                 register-file read port (data one cycle after address)
//   rf_we/rf_waddr/rf_wdata           register-file write-back
//   alu_en/alu_in_sel/alu_op          operand-mux enable, operand-B select, latched opcode
//   rd_q/rs_q/offset                  operand A, operand B, latched immediate
//   alu_done/alu_result               ALU completion pulse and result
//   busy/err                          not-idle status and timeout-abort pulse
module alu_issue_ctrl #(
  parameter int DWIDTH  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [1:0]        rf_raddr,
  input  logic [DWIDTH-1:0] rf_rdata,
  output logic              rf_we,
  output logic [1:0]        rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic              alu_en,
  output logic              alu_in_sel,
  output logic [3:0]        alu_op,
  output logic [DWIDTH-1:0] rd_q,
  output logic [DWIDTH-1:0] rs_q,
  output logic [7:0]        offset,
  input  logic              alu_done,
  input  logic [DWIDTH-1:0] alu_result,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WB    = 3'd5
  } state_t;

  // Last WAIT-cycle count value before the abort fires.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [1:0]  r_rd;
  logic [1:0]  r_rs;
  logic [7:0]  r_cnt;

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd       <= 2'd0;
      r_rs       <= 2'd0;
      r_cnt      <= 8'd0;
      rf_raddr   <= 2'd0;
      rf_we      <= 1'b0;
      rf_waddr   <= 2'd0;
      rf_wdata   <= '0;
      alu_en     <= 1'b0;
      alu_in_sel <= 1'b0;
      alu_op     <= 4'h0;
      rd_q       <= '0;
      rs_q       <= '0;
      offset     <= 8'h00;
      err        <= 1'b0;
    end else begin
      // Single-cycle strobes default low; only the transitions below raise them.
      alu_en <= 1'b0;
      rf_we  <= 1'b0;
      err    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            alu_op     <= instr[15:12];
            r_rd       <= instr[11:10];
            r_rs       <= instr[9:8];
            offset     <= instr[7:0];
            alu_in_sel <= instr[15];
            // NOP is consumed in place; rf_raddr is set up so rd is on the
            // read port during RD_A.
            if (instr[15:12] != 4'h0) begin
              rf_raddr <= instr[11:10];
              r_state  <= S_RD_A;
            end
          end
        end
        S_RD_A: begin
          // rs goes on the port during RD_B even for immediate ops; its data
          // returns in ISSUE and is simply not captured then.
          rf_raddr <= r_rs;
          r_state  <= S_RD_B;
        end
        S_RD_B: begin
          rd_q    <= rf_rdata;
          alu_en  <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!alu_in_sel) begin
            rs_q <= rf_rdata;
          end
          r_cnt   <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // done has priority over the abort on the final WAIT cycle.
          if (alu_done) begin
            rf_wdata <= alu_result;
            rf_waddr <= r_rd;
            rf_we    <= 1'b1;
            r_state  <= S_WB;
          end else if (r_cnt == LP_CNT_LAST) begin
            err     <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose : self-checking bench for alu_issue_ctrl with directed and randomized transactions.
// Latency : inputs driven and outputs sampled on the falling edge of clk.
// Backpr. : the bench offers instructions only while instr_ready is expected high.
module tb_alu_issue_ctrl;

  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [1:0]    rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [1:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          alu_en;
  logic          alu_in_sel;
  logic [3:0]    alu_op;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] rs_q;
  logic [7:0]    offset;
  logic          alu_done;
  logic [DW-1:0] alu_result;
  logic          busy;
  logic          err;

  alu_issue_ctrl #(.DWIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_en(alu_en), .alu_in_sel(alu_in_sel), .alu_op(alu_op),
    .rd_q(rd_q), .rs_q(rs_q), .offset(offset),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Register file the DUT talks to: one-cycle read latency, write on rf_we.
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    rf_rdata <= mem[rf_raddr];
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  // Pulse monitors, sampled mid-cycle.
  int m_en = 0;
  int m_we = 0;
  always @(negedge clk) begin
    if (alu_en) m_en++;
    if (rf_we)  m_we++;
  end

  // Reference model state.
  logic [DW-1:0] e_rf [4];
  logic [3:0]    e_op;
  logic [7:0]    e_off;
  logic          e_sel;
  logic [DW-1:0] e_rdq;
  logic [DW-1:0] e_rsq;
  int            e_en;
  int            e_we;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic model_reset();
    e_op  = 4'h0;
    e_off = 8'h00;
    e_sel = 1'b0;
    e_rdq = '0;
    e_rsq = '0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_rdy",    32'(instr_ready), 32'd1);
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_we",     32'(rf_we),       32'd0);
    chk("rst_en",     32'(alu_en),      32'd0);
    chk("rst_err",    32'(err),         32'd0);
    chk("rst_sel",    32'(alu_in_sel),  32'd0);
    chk("rst_op",     32'(alu_op),      32'd0);
    chk("rst_rdq",    32'(rd_q),        32'd0);
    chk("rst_rsq",    32'(rs_q),        32'd0);
    chk("rst_off",    32'(offset),      32'd0);
    chk("rst_raddr",  32'(rf_raddr),    32'd0);
    chk("rst_waddr",  32'(rf_waddr),    32'd0);
    chk("rst_wdata",  32'(rf_wdata),    32'd0);
  endtask

  task automatic poke_rf(input int idx, input logic [DW-1:0] v);
    mem[idx]  = v;
    e_rf[idx] = v;
  endtask

  // One transaction from an IDLE falling edge back to an IDLE falling edge.
  // d     : WAIT cycle (1..TMO) on which alu_done is driven; otherwise none.
  // stray : drive alu_done through RD_A/RD_B/ISSUE.
  // rst_k : WAIT cycle on which a one-cycle reset is applied (0 = none).
  task automatic run_txn(input logic [15:0] ins, input int d, input bit stray,
                         input int rst_k, input logic [DW-1:0] res);
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    op = ins[15:12];
    rd = ins[11:10];
    rs = ins[9:8];
    chk("idle_rdy", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    nclk();
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    e_op  = op;
    e_off = ins[7:0];
    e_sel = op[3];
    chk("lat_op",  32'(alu_op),     32'(e_op));
    chk("lat_off", 32'(offset),     32'(e_off));
    chk("lat_sel", 32'(alu_in_sel), 32'(e_sel));
    if (op == 4'h0) begin
      chk("nop_busy", 32'(busy), 32'd0);
      return;
    end
    e_en++;
    // RD_A
    chk("rda_busy",  32'(busy),        32'd1);
    chk("rda_rdy",   32'(instr_ready), 32'd0);
    chk("rda_raddr", 32'(rf_raddr),    32'(rd));
    chk("rda_en",    32'(alu_en),      32'd0);
    if (stray) begin
      alu_done   = 1'b1;
      alu_result = 16'($urandom);
    end
    nclk();
    // RD_B
    chk("rdb_raddr", 32'(rf_raddr), 32'(rs));
    chk("rdb_en",    32'(alu_en),   32'd0);
    nclk();
    // ISSUE: alu_en is the third cycle after the accepting edge
    e_rdq = e_rf[rd];
    chk("iss_en",  32'(alu_en), 32'd1);
    chk("iss_rdq", 32'(rd_q),   32'(e_rdq));
    nclk();
    alu_done = 1'b0;
    if (!e_sel) e_rsq = e_rf[rs];
    chk("wait_rsq", 32'(rs_q),   32'(e_rsq));
    chk("wait_en",  32'(alu_en), 32'd0);
    for (int k = 1; k <= TMO; k++) begin
      chk("wait_busy", 32'(busy), 32'd1);
      if (k == rst_k) begin
        rst         = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h1500;
        alu_done    = 1'b1;
        alu_result  = 16'($urandom);
        nclk();
        rst         = 1'b0;
        instr_valid = 1'b0;
        model_reset();
        chk_reset_outs();
        nclk();
        alu_done = 1'b0;
        chk("late_we",   32'(rf_we), 32'd0);
        chk("late_busy", 32'(busy),  32'd0);
        return;
      end
      if (k == d) begin
        alu_done   = 1'b1;
        alu_result = res;
      end
      nclk();
      if (k == d) begin
        alu_done = 1'b0;
        chk("wb_we",    32'(rf_we),    32'd1);
        chk("wb_waddr", 32'(rf_waddr), 32'(rd));
        chk("wb_wdata", 32'(rf_wdata), 32'(res));
        chk("wb_err",   32'(err),      32'd0);
        e_rf[rd] = res;
        e_we++;
        nclk();
        chk("post_wb_rdy", 32'(instr_ready), 32'd1);
        chk("post_wb_we",  32'(rf_we),       32'd0);
        return;
      end
    end
    // Abort: err is registered, so it shows together with the return to IDLE.
    chk("tmo_err", 32'(err),         32'd1);
    chk("tmo_rdy", 32'(instr_ready), 32'd1);
    chk("tmo_we",  32'(rf_we),       32'd0);
    nclk();
    chk("tmo_err_clr", 32'(err), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b1;
    instr       = 16'h2600;
    alu_done    = 1'b0;
    alu_result  = '0;
    e_en        = 0;
    e_we        = 0;
    for (int i = 0; i < 4; i++) poke_rf(i, '0);
    model_reset();
    nclk();
    nclk();
    rst         = 1'b0;
    instr_valid = 1'b0;
    chk_reset_outs();
    nclk();
    chk("rst_valid_ignored", 32'(busy), 32'd0);

    // Register op: R1 + R2 style, result 0x0046 on the first WAIT cycle.
    poke_rf(1, 16'h0012);
    poke_rf(2, 16'h0034);
    run_txn(16'h2600, 1, 1'b0, 0, 16'h0046);

    // Immediate op: rs_q must keep the previous operand.
    poke_rf(3, 16'h0100);
    run_txn(16'h8C7F, 2, 1'b0, 0, 16'h017F);

    // NOP held for three cycles: each one consumed in IDLE.
    instr_valid = 1'b1;
    instr       = 16'h0FFF;
    for (int i = 0; i < 3; i++) begin
      nclk();
      chk("nop_busy", 32'(busy),        32'd0);
      chk("nop_rdy",  32'(instr_ready), 32'd1);
      chk("nop_en",   32'(alu_en),      32'd0);
    end
    instr_valid = 1'b0;
    e_op  = 4'h0;
    e_off = 8'hFF;
    e_sel = 1'b0;
    chk("nop_off", 32'(offset), 32'hFF);
    chk("nop_rdq", 32'(rd_q),   32'(e_rdq));

    // Watchdog: no done, then done exactly on the last WAIT cycle.
    run_txn(16'h3100, 0,   1'b0, 0, 16'h0000);
    run_txn(16'h4300, TMO, 1'b0, 0, 16'hBEEF);

    // Reset in the middle of WAIT with a late done.
    run_txn(16'h5700, 0, 1'b0, 5, 16'h0000);

    // Stray done before WAIT is ignored.
    run_txn(16'h6B00, 3, 1'b1, 0, 16'h1234);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] ins;
      int          d;
      int          rk;
      ins = 16'($urandom);
      d   = $urandom_range(0, TMO + 2);
      rk  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, TMO) : 0;
      run_txn(ins, d, 1'($urandom_range(0, 1)), rk, 16'($urandom));
    end

    nclk();
    chk("cnt_alu_en", 32'(m_en), 32'(e_en));
    chk("cnt_rf_we",  32'(m_we), 32'(e_we));
    for (int i = 0; i < 4; i++) chk("rf_final", 32'(mem[i]), 32'(e_rf[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Single-issue sequencer that feeds the ALU operand-mux stage.
- Accepts one 16-bit instruction per transaction over a valid/ready handshake.
- Reads operands from a 4-entry single-read-port register file, one operand per cycle.
- Issues a one-cycle enable to the operand mux/ALU and waits for the ALU done pulse.
- Writes the result back, with a watchdog that aborts a hung ALU operation.

Parameters:
DWIDTH, 16, data width of register file, operands and ALU result
TIMEOUT, 15, max cycles spent in WAIT before abort (1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept (high only in IDLE)
instr  input  16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] offset
rf_raddr  output  2  register file read address
rf_rdata  input  DWIDTH  read data, valid one cycle after rf_raddr
rf_we  output  1  write-back strobe
rf_waddr  output  2  write-back address
rf_wdata  output  DWIDTH  write-back data
alu_en  output  1  one-cycle operand-mux enable
alu_in_sel  output  1  1 = immediate operand (offset), 0 = register rs
alu_op  output  4  latched opcode
rd_q  output  DWIDTH  operand A
rs_q  output  DWIDTH  operand B
offset  output  8  latched immediate
alu_done  input  1  ALU result valid pulse
alu_result  input  DWIDTH  ALU result, sampled with alu_done
busy  output  1  state != IDLE
err  output  1  one-cycle pulse on timeout abort

Behaviour:
- All outputs registered or decoded from state. No combinational path from inputs to outputs, except instr_ready = (state == IDLE).
- Reset (any cycle, including mid-transaction):
  - state goes to IDLE.
  - rf_we, alu_en, err, alu_in_sel, alu_op, rd_q, rs_q, offset, rf_raddr, rf_waddr, rf_wdata all go to 0.
  - The watchdog counter clears.
  - A pending instr_valid in the reset cycle is not accepted.
- States: IDLE, RD_A, RD_B, ISSUE, WAIT, WB.
- IDLE:
  - On instr_valid & instr_ready, latch op, rd, rs, offset.
  - alu_in_sel <= op[3].
  - If op == 4'h0 (NOP), stay in IDLE; nothing else changes.
  - Otherwise go to RD_A.
- RD_A: rf_raddr = rd. Go to RD_B.
- RD_B:
  - rd_q <= rf_rdata.
  - rf_raddr = rs. Go to ISSUE.
- ISSUE:
  - If alu_in_sel = 0, rs_q <= rf_rdata; otherwise rs_q holds.
  - alu_en = 1 for exactly this cycle. Go to WAIT with the counter cleared.
- WAIT:
  - Counter increments each cycle.
  - If alu_done = 1: capture alu_result into rf_wdata and go to WB. done wins if it coincides with the timeout cycle.
  - Else if counter == TIMEOUT - 1: err = 1 for one cycle, go to IDLE, no write-back.
- WB:
  - rf_we = 1 for exactly this cycle, with rf_waddr = rd and rf_wdata = captured result.
  - Go to IDLE.
- alu_done outside WAIT is ignored.
- Fixed latencies:
  - Accept edge to alu_en high: 3 cycles (alu_en asserted during the 3rd cycle after acceptance).
  - alu_done sampled to rf_we high: 1 cycle.
- Back-to-back: instr_ready rises the cycle after WB or after an err abort. Minimum transaction is 6 cycles (accept through WB).
- rd_q, rs_q, offset and alu_op hold their values until the next accepted instruction's capture points.
- Immediate ops (op[3] = 1) still spend a cycle in RD_B reading rs; the read data is discarded.

Test Plan:
- Reset then reg-op: R1=16'h0012, R2=16'h0034; instr=16'h2600 (op 2, rd 1, rs 2).
  - Expect rd_q=0012, rs_q=0034, alu_in_sel=0, alu_en high exactly 3 cycles after accept.
  - Drive alu_done with result 16'h0046 one cycle later → next cycle rf_we=1, rf_waddr=1, rf_wdata=0046, then instr_ready=1.
- Immediate op: instr=16'h8C7F (op 8, rd 3, offset 7F), R3=16'h0100.
  - Expect alu_in_sel=1, offset=7F, rd_q=0100, rs_q unchanged from the previous transaction.
- NOP: instr=16'h0FFF with valid held for 3 cycles → busy stays 0, alu_en and rf_we never assert, three NOPs consumed.
- Timeout with TIMEOUT=15: withhold alu_done.
  - Expect err pulse on the 15th WAIT cycle, no rf_we, instr_ready high the next cycle.
  - Repeat with alu_done on that same cycle → expect WB, no err.
- Reset mid-WAIT: assert rst for 1 cycle → all outputs 0, state IDLE, and a late alu_done causes no rf_we.
- Stray alu_done during RD_A/RD_B/ISSUE → ignored; the transaction still waits for a done in WAIT.
